// File: rtl/conv_scheduler.sv
// rtl/conv_scheduler.sv - address/control sequencer for a KxK sliding-window convolution
// Walks output pixels row-major and issues one MAC term per cycle with 1-cycle-delayed MAC strobes.
module conv_scheduler #(
  parameter int INW         = 24,
  parameter int R           = 9,
  parameter int C           = 8,
  parameter int MAXK        = 4,
  parameter int K_BITS      = $clog2(MAXK + 1),
  parameter int X_ADDR_BITS = $clog2(R * C),
  parameter int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic                   out_ready,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic                   mac_en,
  output logic                   mac_first,
  output logic                   mac_last,
  output logic                   compute_finished
);

  localparam int CNT = X_ADDR_BITS + 1;
  localparam logic [CNT-1:0] R_L = CNT'(R);
  localparam logic [CNT-1:0] C_L = CNT'(C);

  // INW only documents the attached memories; no datapath lives here.
  if (INW <= 0) begin : g_inw_unused
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [CNT-1:0]         i_q, i_d;
  logic [CNT-1:0]         j_q, j_d;
  logic [CNT-1:0]         row_base_q, row_base_d;
  logic [CNT-1:0]         x_row_q, x_row_d;
  logic [K_BITS-1:0]      m_q, m_d;
  logic [K_BITS-1:0]      n_q, n_d;
  logic [W_ADDR_BITS-1:0] w_q, w_d;
  logic                   en_q, first_q, last_q;

  logic           issue, term_first, term_last;
  logic           last_n, last_m, last_j, last_i;
  logic [CNT-1:0] k_ext;

  assign k_ext  = CNT'(k_q);
  assign last_n = (n_q == k_q - K_BITS'(1));
  assign last_m = (m_q == k_q - K_BITS'(1));
  assign last_j = (j_q + k_ext == C_L);
  assign last_i = (i_q + k_ext == R_L);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    row_base_d  = row_base_q;
    x_row_d     = x_row_q;
    m_d         = m_q;
    n_d         = n_q;
    w_d         = w_q;
    issue       = 1'b0;
    term_first  = 1'b0;
    term_last   = 1'b0;
    X_read_addr = '0;
    W_read_addr = '0;

    case (state_q)
      S_IDLE: begin
        if (inputs_loaded) begin
          k_d        = K;
          i_d        = '0;
          j_d        = '0;
          row_base_d = '0;
          x_row_d    = '0;
          m_d        = '0;
          n_d        = '0;
          w_d        = '0;
          state_d    = (K == '0) ? S_DRAIN : S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (out_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        issue       = 1'b1;
        term_first  = (m_q == '0) && (n_q == '0);
        term_last   = last_n && last_m;
        X_read_addr = X_ADDR_BITS'(x_row_q + CNT'(n_q));
        W_read_addr = w_q;
        if (!last_n) begin
          n_d = n_q + K_BITS'(1);
          w_d = w_q + W_ADDR_BITS'(1);
        end else if (!last_m) begin
          // Next kernel row: X jumps by one matrix row, W keeps counting.
          n_d     = '0;
          m_d     = m_q + K_BITS'(1);
          x_row_d = x_row_q + C_L;
          w_d     = w_q + W_ADDR_BITS'(1);
        end else begin
          n_d = '0;
          m_d = '0;
          w_d = '0;
          if (last_j) begin
            j_d        = '0;
            i_d        = i_q + CNT'(1);
            row_base_d = row_base_q + C_L;
            x_row_d    = row_base_q + C_L;
          end else begin
            j_d     = j_q + CNT'(1);
            x_row_d = row_base_q + j_q + CNT'(1);
          end
          if (last_j && last_i) state_d = S_DRAIN;
          else if (out_ready)   state_d = S_ISSUE;
          else                  state_d = S_WAIT_SPACE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      row_base_q <= '0;
      x_row_q    <= '0;
      m_q        <= '0;
      n_q        <= '0;
      w_q        <= '0;
      en_q       <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      i_q        <= i_d;
      j_q        <= j_d;
      row_base_q <= row_base_d;
      x_row_q    <= x_row_d;
      m_q        <= m_d;
      n_q        <= n_d;
      w_q        <= w_d;
      en_q       <= issue;
      first_q    <= term_first;
      last_q     <= term_last;
    end
  end

  // Strobes trail the address by one cycle to line up with memory read data.
  assign mac_en           = en_q;
  assign mac_first        = first_q;
  assign mac_last         = last_q;
  assign compute_finished = (state_q == S_DONE);

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL have parameter INW, default 24, data width of the attached input memories (documentation only; no datapath here).
REQ-002 SHALL have parameter R, default 9, input matrix rows.
REQ-003 SHALL have parameter C, default 8, input matrix columns.
REQ-004 SHALL have parameter MAXK, default 4, maximum kernel size; derived K_BITS=clog2(MAXK+1), X_ADDR_BITS=clog2(R*C), W_ADDR_BITS=clog2(MAXK*MAXK).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port inputs_loaded, input, 1, input memories hold a complete W, B, X set.
REQ-008 SHALL have port K, input, K_BITS, kernel size; sampled at job start.
REQ-009 SHALL have port out_ready, input, 1, downstream can accept one more output pixel.
REQ-010 SHALL have port X_read_addr, output, X_ADDR_BITS, X memory read address.
REQ-011 SHALL have port W_read_addr, output, W_ADDR_BITS, W memory read address.
REQ-012 SHALL have port mac_en, output, 1, X_data/W_data valid this cycle; accumulate product.
REQ-013 SHALL have port mac_first, output, 1, qualifies mac_en; first term of a pixel (accumulator loads B + product).
REQ-014 SHALL have port mac_last, output, 1, qualifies mac_en; last term of a pixel (pixel result complete after this cycle).
REQ-015 SHALL have port compute_finished, output, 1, one-cycle pulse; job complete, input memories may reload.

Function
REQ-016 SHALL implement states IDLE, WAIT_SPACE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: on inputs_loaded=1, SHALL latch K into k_reg, clear pixel counters i=j=0, go to WAIT_SPACE; if K=0, go to DRAIN instead (zero pixels).
REQ-018 WAIT_SPACE: SHALL go to ISSUE when out_ready=1; else hold; no addresses issued.
REQ-019 ISSUE: SHALL issue one term per cycle for pixel (i,j), terms (m,n) in row-major order, m,n in 0..k_reg-1, with no stall inside a pixel.
REQ-020 Term address SHALL be X_read_addr=(i+m)*C+(j+n), W_read_addr=m*k_reg+n, computed by incremental counters (no general multiplier required).
REQ-021 Pixel order SHALL be row-major: j 0..C-k_reg, then i 0..R-k_reg; total (R-k_reg+1)*(C-k_reg+1) pixels.
REQ-022 After the last term of a non-final pixel, SHALL start term 0 of the next pixel the following cycle if out_ready=1, else go to WAIT_SPACE.
REQ-023 After the last term of the final pixel, SHALL go to DRAIN for one cycle, then DONE for one cycle, then IDLE.
REQ-024 mac_en, mac_first, mac_last SHALL be registered copies of issue-valid, term==0, term==last, delayed exactly 1 cycle from the address cycle (matches 1-cycle memory read latency).
REQ-025 compute_finished SHALL be 1 only in DONE, i.e. one cycle after the final mac_last (two cycles after job start when K=0).
REQ-026 When not in ISSUE, X_read_addr and W_read_addr SHALL be 0.
REQ-027 K=1: mac_first and mac_last SHALL both assert on every mac_en.
REQ-028 K>R or K>C is illegal input; behaviour undefined, no check required.
REQ-029 inputs_loaded changes outside IDLE SHALL be ignored; in the cycle after DONE, inputs_loaded is low and no new job starts.
REQ-030 out_ready SHALL be sampled only at pixel boundaries (WAIT_SPACE and last-term cycle).

Reset
REQ-031 reset=0 at a clock edge SHALL force IDLE, clear all counters and k_reg, and drive all outputs to 0 the following cycle, including mid-ISSUE (pending mac_en dropped, no compute_finished).

Verification
REQ-032 R=9,C=8,K=3,out_ready=1: first pixel X addr 0,1,2,8,9,10,16,17,18, W 0..8; 42 pixels, 378 mac_en cycles contiguous; last term X=71,W=8; compute_finished one cycle after final mac_last.
REQ-033 K=1: 72 pixels, X_read_addr 0..71 consecutive, W_read_addr 0, mac_first=mac_last=1 on every mac_en.
REQ-034 K=4: 30 pixels x 16 terms; pixel (0,1) starts X=1; final pixel (5,4) starts X=44, ends X=71, W=15.
REQ-035 K=0 with inputs_loaded=1: no mac_en, compute_finished pulses exactly two cycles later.
REQ-036 K=3, out_ready=0 during pixel 2's boundary for 5 cycles: 5-cycle gap in mac_en, pixel 2 then resumes X=2; job still totals 378 mac_en.
REQ-037 reset=0 at term 4 of pixel 0: all outputs 0 next cycle; restart with inputs_loaded=1 repeats REQ-032 exactly.
